spi_slave_imp: RTL and testbench

SPI peripheral (slave) endpoint, the counterpart of the team's SPI master block. It receives bytes on MOSI and returns bytes on MISO in SPI mode 0 (CPOL=0, CPHA=0), 8-bit frames, MSB first. A core accesses it through an OBI register interface: a TX holding register, an RX data register and a status register. All SPI inputs are asynchronous to clk_i and are synchronised internally.

---
 rtl/spi_slave_imp.sv | 191 +++++++++++++++++++
 tb/tb_spi_slave_imp.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_imp.sv
// spi_slave_imp: SPI mode-0 peripheral endpoint (8-bit frames, MSB first)
// with an OBI register interface.
//   OBI  : obi_req_i/obi_gnt_o address phase; obi_rvalid_o/obi_rdata_o
//          response one cycle after every accepted request.
//          0x0 TXDATA (W), 0x4 RXDATA (R), 0x8 STATUS
//          (bit0 rx_valid, bit1 tx_empty, bit2 busy, bit3 overrun; W1C overrun).
//   SPI  : spi_ss_i/spi_sclk_i/spi_mosi_i are asynchronous and are synchronised
//          here; spi_miso_o is registered and held 0 while deselected.
//   IRQ  : spi_rx_irq_o follows rx_valid.
module spi_slave_imp #(
   parameter int unsigned ADDR_WIDTH   = 32,
   parameter int unsigned DATA_WIDTH   = 32,
   parameter logic [7:0]  TX_IDLE_BYTE = 8'hFF
) (
   input  logic                    clk_i,
   input  logic                    rstn_i,
   input  logic                    obi_req_i,
   output logic                    obi_gnt_o,
   input  logic [ADDR_WIDTH-1:0]   obi_addr_i,
   input  logic [DATA_WIDTH-1:0]   obi_wdata_i,
   input  logic                    obi_we_i,
   input  logic [DATA_WIDTH/8-1:0] obi_be_i,
   output logic                    obi_rvalid_o,
   output logic [DATA_WIDTH-1:0]   obi_rdata_o,
   input  logic                    spi_ss_i,
   input  logic                    spi_sclk_i,
   input  logic                    spi_mosi_i,
   output logic                    spi_miso_o,
   output logic                    spi_rx_irq_o
);

   localparam logic [ADDR_WIDTH-1:0] ADDR_TX = ADDR_WIDTH'(32'h0);
   localparam logic [ADDR_WIDTH-1:0] ADDR_RX = ADDR_WIDTH'(32'h4);
   localparam logic [ADDR_WIDTH-1:0] ADDR_ST = ADDR_WIDTH'(32'h8);

   typedef enum logic {IDLE, ACTIVE} state_t;

   // ---------------- synchronisers ----------------
   // [0] first flop, [1] synchronised value, [2] previous synchronised value.
   // SS resets high so the block comes up deselected and not busy.
   logic [2:0] ss_sr, sclk_sr;
   logic [1:0] mosi_sr;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         ss_sr   <= 3'b111;
         sclk_sr <= 3'b000;
         mosi_sr <= 2'b00;
      end else begin
         ss_sr   <= {ss_sr[1:0], spi_ss_i};
         sclk_sr <= {sclk_sr[1:0], spi_sclk_i};
         mosi_sr <= {mosi_sr[0], spi_mosi_i};
      end
   end

   logic ss_fall, ss_rise, sclk_rise, sclk_fall, mosi_s, busy;
   assign ss_fall   =  ss_sr[2]   & ~ss_sr[1];
   assign ss_rise   = ~ss_sr[2]   &  ss_sr[1];
   assign sclk_rise = ~sclk_sr[2] &  sclk_sr[1];
   assign sclk_fall =  sclk_sr[2] & ~sclk_sr[1];
   assign mosi_s    =  mosi_sr[1];
   assign busy      = ~ss_sr[1];

   // ---------------- OBI decode ----------------
   logic fire, wr_tx, rd_rx, clr_ovr;
   assign obi_gnt_o = obi_req_i;
   assign fire      = obi_req_i;
   assign wr_tx     = fire &  obi_we_i & (obi_addr_i == ADDR_TX) & obi_be_i[0];
   assign rd_rx     = fire & ~obi_we_i & (obi_addr_i == ADDR_RX);
   assign clr_ovr   = fire &  obi_we_i & (obi_addr_i == ADDR_ST) & obi_be_i[0]
                      & obi_wdata_i[3];

   // ---------------- SPI engine state ----------------
   state_t     state;
   logic [2:0] bit_cnt;
   logic [6:0] tx_shift;   // bits still to go out after the one on miso
   logic [6:0] rx_shift;
   logic [7:0] rx_byte;
   logic [7:0] tx_hold;
   logic       tx_full;
   logic       rx_valid;
   logic       overrun;
   logic       reload;     // 8th rising edge seen; next falling edge loads a frame

   logic       active_ok, byte_done, load, ovr_set;
   logic [7:0] ld_byte;

   // an SS rising edge aborts the frame and masks any coincident sclk edge
   assign active_ok = (state == ACTIVE) & ~ss_rise;
   assign byte_done = active_ok & sclk_rise & (bit_cnt == 3'd7);
   assign load      = ((state == IDLE) & ss_fall) | (active_ok & sclk_fall & reload);
   // load samples the holding register before any same-cycle write lands
   assign ld_byte   = tx_full ? tx_hold : TX_IDLE_BYTE;
   assign ovr_set   = byte_done & rx_valid & ~rd_rx;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state      <= IDLE;
         bit_cnt    <= 3'd0;
         tx_shift   <= 7'd0;
         rx_shift   <= 7'd0;
         rx_byte    <= 8'd0;
         tx_hold    <= 8'd0;
         tx_full    <= 1'b0;
         rx_valid   <= 1'b0;
         overrun    <= 1'b0;
         reload     <= 1'b0;
         spi_miso_o <= 1'b0;
      end else begin
         if (wr_tx)          tx_hold <= obi_wdata_i[7:0];
         if (wr_tx)          tx_full <= 1'b1;
         else if (load)      tx_full <= 1'b0;

         if (byte_done)      rx_valid <= 1'b1;
         else if (rd_rx)     rx_valid <= 1'b0;

         if (ovr_set)        overrun <= 1'b1;
         else if (clr_ovr)   overrun <= 1'b0;

         case (state)
            IDLE: begin
               spi_miso_o <= 1'b0;
               if (ss_fall) begin
                  state      <= ACTIVE;
                  tx_shift   <= ld_byte[6:0];
                  spi_miso_o <= ld_byte[7];
                  bit_cnt    <= 3'd0;
                  reload     <= 1'b0;
               end
            end
            ACTIVE: begin
               if (ss_rise) begin
                  state      <= IDLE;
                  bit_cnt    <= 3'd0;
                  reload     <= 1'b0;
                  spi_miso_o <= 1'b0;
               end else begin
                  if (sclk_rise) begin
                     rx_shift <= {rx_shift[5:0], mosi_s};
                     bit_cnt  <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
                        rx_byte <= {rx_shift, mosi_s};
                        reload  <= 1'b1;
                     end
                  end
                  if (sclk_fall) begin
                     if (reload) begin
                        tx_shift   <= ld_byte[6:0];
                        spi_miso_o <= ld_byte[7];
                        reload     <= 1'b0;
                     end else begin
                        tx_shift   <= {tx_shift[5:0], 1'b0};
                        spi_miso_o <= tx_shift[6];
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign spi_rx_irq_o = rx_valid;

   // ---------------- OBI response ----------------
   logic [DATA_WIDTH-1:0] rd_mux;

   always_comb begin
      rd_mux = '0;
      if (obi_addr_i == ADDR_RX)      rd_mux = DATA_WIDTH'(rx_byte);
      else if (obi_addr_i == ADDR_ST) rd_mux = DATA_WIDTH'({overrun, busy, ~tx_full, rx_valid});
   end

   logic vld_pipe;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         vld_pipe    <= 1'b0;
         obi_rdata_o <= '0;
      end else begin
         vld_pipe    <= fire;
         obi_rdata_o <= (fire & ~obi_we_i) ? rd_mux : '0;
      end
   end

   assign obi_rvalid_o = vld_pipe;

   logic unused_bits;
   assign unused_bits = ^{obi_wdata_i[DATA_WIDTH-1:8], obi_be_i[DATA_WIDTH/8-1:1]};

endmodule

// File: tb/tb_spi_slave_imp.sv
module tb_spi_slave_imp;

   logic        clk = 1'b0;
   logic        rstn;
   logic        req, gnt, we, rvalid;
   logic [31:0] addr, wdata, rdata;
   logic [3:0]  be;
   logic        ss, sclk, mosi, miso, irq;

   always #5 clk = ~clk;

   spi_slave_imp #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TX_IDLE_BYTE(8'hFF)) dut (
      .clk_i(clk), .rstn_i(rstn),
      .obi_req_i(req), .obi_gnt_o(gnt), .obi_addr_i(addr), .obi_wdata_i(wdata),
      .obi_we_i(we), .obi_be_i(be), .obi_rvalid_o(rvalid), .obi_rdata_o(rdata),
      .spi_ss_i(ss), .spi_sclk_i(sclk), .spi_mosi_i(mosi), .spi_miso_o(miso),
      .spi_rx_irq_o(irq)
   );

   int          n_chk = 0;
   int          n_err = 0;
   logic [31:0] exp_q[$];
   logic [31:0] mon_exp;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got=0x%0h want=0x%0h", nm, act, exp);
      end
   endtask

   // scoreboard: every response is compared against the oldest expectation
   always @(negedge clk) begin
      if (rstn && rvalid) begin
         if (exp_q.size() == 0) chk("unexpected rvalid", 32'd1, 32'd0);
         else begin
            mon_exp = exp_q.pop_front();
            chk($sformatf("rdata @%0t", $time), rdata, mon_exp);
         end
      end
   end

   task automatic wclk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic obi(input logic [31:0] a, input logic w, input logic [31:0] d,
                      input logic [3:0] b, input logic [31:0] exp);
      @(negedge clk);
      req = 1'b1; addr = a; we = w; wdata = d; be = b;
      exp_q.push_back(w ? 32'd0 : exp);
      #1 chk("gnt follows req", {31'd0, gnt}, 32'd1);
      @(negedge clk);
      req = 1'b0; we = 1'b0;
      chk("rvalid one cycle after fire", {31'd0, rvalid}, 32'd1);
      @(negedge clk);
      chk("rvalid single cycle", {31'd0, rvalid}, 32'd0);
   endtask

   // one byte (or a partial byte) of mode-0 master clocking, sclk = clk/8
   task automatic spi_byte(input logic [7:0] mo, input logic [7:0] exp_mi,
                           input int nbits, input logic chk_irq);
      for (int i = 0; i < nbits; i++) begin
         mosi = mo[7-i];
         wclk(4);
         chk($sformatf("miso bit%0d", 7-i), {31'd0, miso}, {31'd0, exp_mi[7-i]});
         sclk = 1'b1;
         wclk(4);
         if (chk_irq && i == 7) chk("irq within 4 clk", {31'd0, irq}, 32'd1);
         sclk = 1'b0;
      end
   endtask

   task automatic ss_low();
      ss = 1'b0;
      wclk(8);
   endtask

   task automatic ss_high();
      wclk(4);
      ss = 1'b1;
      wclk(6);
      chk("miso idle", {31'd0, miso}, 32'd0);
   endtask

   task automatic frame(input logic [7:0] mo, input logic [7:0] exp_mi, input logic chk_irq);
      ss_low();
      spi_byte(mo, exp_mi, 8, chk_irq);
      ss_high();
   endtask

   typedef struct {
      logic [31:0] a;
      logic        w;
      logic [31:0] d;
      logic [3:0]  b;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl[12];

   initial begin
      tbl[0]  = '{32'h8,   1'b0, 32'h0,  4'hF, 32'h2};
      tbl[1]  = '{32'h0,   1'b0, 32'h0,  4'hF, 32'h0};
      tbl[2]  = '{32'h4,   1'b0, 32'h0,  4'hF, 32'h0};
      tbl[3]  = '{32'hC,   1'b0, 32'h0,  4'hF, 32'h0};
      tbl[4]  = '{32'h4,   1'b1, 32'hAB, 4'hF, 32'h0};
      tbl[5]  = '{32'h4,   1'b0, 32'h0,  4'hF, 32'h0};
      tbl[6]  = '{32'h0,   1'b1, 32'h55, 4'hE, 32'h0};
      tbl[7]  = '{32'h8,   1'b0, 32'h0,  4'hF, 32'h2};
      tbl[8]  = '{32'h8,   1'b1, 32'hF,  4'hF, 32'h0};
      tbl[9]  = '{32'h8,   1'b0, 32'h0,  4'hF, 32'h2};
      tbl[10] = '{32'h108, 1'b0, 32'h0,  4'hF, 32'h0};
      tbl[11] = '{32'h104, 1'b0, 32'h0,  4'hF, 32'h0};

      rstn = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
      ss = 1'b1; sclk = 1'b0; mosi = 1'b0;
      wclk(2);
      #1;
      chk("reset gnt",    {31'd0, gnt},    32'd0);
      chk("reset rvalid", {31'd0, rvalid}, 32'd0);
      chk("reset rdata",  rdata,           32'd0);
      chk("reset miso",   {31'd0, miso},   32'd0);
      chk("reset irq",    {31'd0, irq},    32'd0);
      @(negedge clk);
      rstn = 1'b1;
      wclk(4);

      // register map after reset
      for (int i = 0; i < 12; i++)
         obi(tbl[i].a, tbl[i].w, tbl[i].d, tbl[i].b, tbl[i].exp);

      // held byte goes out while a frame comes in
      obi(32'h0, 1'b1, 32'hA5, 4'h1, 32'h0);
      frame(8'h3C, 8'hA5, 1'b1);
      obi(32'h8, 1'b0, 32'h0, 4'hF, 32'h3);
      obi(32'h4, 1'b0, 32'h0, 4'hF, 32'h3C);
      obi(32'h8, 1'b0, 32'h0, 4'hF, 32'h2);

      // underrun sends the idle byte, receive still works
      frame(8'h96, 8'hFF, 1'b1);
      obi(32'h4, 1'b0, 32'h0, 4'hF, 32'h96);

      // back-to-back frames: first uses the held byte, second underruns; overrun
      obi(32'h0, 1'b1, 32'hC3, 4'h1, 32'h0);
      ss_low();
      spi_byte(8'h11, 8'hC3, 8, 1'b1);
      spi_byte(8'h22, 8'hFF, 8, 1'b0);
      ss_high();
      obi(32'h8, 1'b0, 32'h0, 4'hF, 32'hB);
      obi(32'h4, 1'b0, 32'h0, 4'hF, 32'h22);
      obi(32'h8, 1'b1, 32'h8, 4'h1, 32'h0);
      obi(32'h8, 1'b0, 32'h0, 4'hF, 32'h2);

      // aborted frame is discarded, next frame is clean
      ss_low();
      spi_byte(8'hF0, 8'hFF, 5, 1'b0);
      ss_high();
      obi(32'h8, 1'b0, 32'h0, 4'hF, 32'h2);
      frame(8'h5A, 8'hFF, 1'b1);
      obi(32'h4, 1'b0, 32'h0, 4'hF, 32'h5A);

      // async reset mid-frame
      frame(8'h81, 8'hFF, 1'b0);
      obi(32'h0, 1'b1, 32'h77, 4'h1, 32'h0);
      obi(32'h8, 1'b0, 32'h0, 4'hF, 32'h1);
      ss_low();
      spi_byte(8'h00, 8'h77, 3, 1'b0);
      chk("irq before reset", {31'd0, irq}, 32'd1);
      wclk(1);
      #2 rstn = 1'b0;
      #1;
      chk("midframe reset rvalid", {31'd0, rvalid}, 32'd0);
      chk("midframe reset rdata",  rdata,           32'd0);
      chk("midframe reset miso",   {31'd0, miso},   32'd0);
      chk("midframe reset irq",    {31'd0, irq},    32'd0);
      ss = 1'b1;
      wclk(2);
      rstn = 1'b1;
      wclk(4);
      obi(32'h8, 1'b0, 32'h0, 4'hF, 32'h2);
      obi(32'h4, 1'b0, 32'h0, 4'hF, 32'h0);

      wclk(4);
      chk("scoreboard drained", exp_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
